tree_loader: RTL and testbench
==============================

Name: tree_loader

Overview:
Writer side of the tree-evaluation memories. Accepts a 32-bit word stream (DMA/host) carrying one frame: header, packed 64-bit node entries, feature words. Validates each entry and drives write ports of the node RAM and feature RAM that the tree traversal engine reads by node_index/feature_index. Pulses load_done when a complete, error-free frame is stored, so the controller may issue start to the traversal engine.

Parameters:
N_NODE_AND_LEAFS, 256, node RAM depth (entries of 64 bits)
N_FEATURE, 32, feature RAM depth (entries of 32 bits)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_data  in  32  stream word
in_valid  in  1  in_data valid
in_last  in  1  final word of frame
in_ready  out  1  block accepts word (transfer = in_valid & in_ready)
node_we  out  1  node RAM write strobe, 1-cycle pulse
node_waddr  out  $clog2(N_NODE_AND_LEAFS)  node RAM address
node_wdata  out  64  node entry
feat_we  out  1  feature RAM write strobe, 1-cycle pulse
feat_waddr  out  $clog2(N_FEATURE)  feature RAM address
feat_wdata  out  32  signed feature value
load_busy  out  1  frame in progress (header accepted, not finished)
load_done  out  1  1-cycle pulse, frame stored without error
err  out  1  sticky error flag, cleared on next accepted header
err_code  out  2  0 none, 1 bad header, 2 length mismatch, 3 bad node

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE; counters 0.
- Frame: header word, then 2*N node words (low word first, then high), then F feature words; in_last exactly on the final feature word.
- Header: [15:0]=N node count, [31:16]=F feature count. Valid iff 1<=N<=N_NODE_AND_LEAFS and 1<=F<=N_FEATURE.
- Node entry = {hi, lo}: [63:32] signed threshold/leaf value, [23:16] right child index, [15:8] f_index, [0] leaf_or_node (1 decision, 0 leaf); padding bits [31:24],[7:1] stored as received.
- Node check (decision nodes only): right index > current addr and < N, f_index < F; else err_code 3. Leaves unchecked.
- States: IDLE -> (header ok) NODE_LO; (header bad) err=1, code 1, -> DRAIN, or stay IDLE if header word carries in_last.
- NODE_LO: latch lo -> NODE_HI. NODE_HI: check entry; ok -> write at node_waddr=node count; last node -> FEAT else NODE_LO; bad -> no write, code 3, DRAIN.
- FEAT: write at feat_waddr=feature count; on last feature word with in_last -> DONE; without in_last -> code 2, DRAIN.
- in_last on any word before final feature word -> code 2, no write of that word/pending lo, -> IDLE.
- DRAIN: in_ready=1, discard words until in_last handshake, -> IDLE. No writes.
- DONE: one cycle, in_ready=0, load_done=1, -> IDLE.
- in_ready=1 in all states except DONE. in_valid low stalls with no state change; no internal backpressure.
- Write latency: node_we/feat_we, address, data registered, asserted the cycle after the accepting handshake; addresses start at 0, increment by 1 per write.
- load_busy=1 from cycle after header accepted until cycle after IDLE re-entered; 0 in DRAIN after error.
- First error wins: err_code holds first code until next accepted header.
- Reset mid-frame: immediate return to IDLE, pending strobes deasserted, partially written RAM content left as is; no load_done.

Test Plan:
- Header N=3,F=2; nodes {thr=100,r=2,f=1,dec},{leaf 7},{leaf -5}; features 50,200 with in_last -> node_we x3 at addr 0,1,2 with node_wdata 0x00000064_00020101, 0x00000007_00000000, 0xFFFFFFFB_00000000; feat_we at 0,1; load_done pulse 1 cycle after final handshake; err=0.
- Header N=0,F=4 then 3 words, last with in_last -> err=1, code 1, zero writes, load_done never, IDLE after in_last.
- Node 0 decision with right=5, N=3 -> code 3, node_we never for node 0, remaining words drained to in_last, next good frame clears err and completes.
- in_last on 2nd feature word of F=3 frame -> code 2, feat_we only for feature 0, back to IDLE, in_ready=1.
- Same good frame with in_valid low for 1-3 random cycles between words -> identical write sequence and values as first test.
- rst_n low while in NODE_HI of node 1 -> outputs at reset values next edge, no further writes; new frame after release loads correctly.

Source files
------------

// File: rtl/tree_loader.sv
// tree_loader: turns one header/node/feature word frame into node RAM and feature RAM writes.
// Latency: write strobe, address and data are registered, one cycle after the accepting handshake.
// Backpressure: in_ready drops only for the single DONE cycle; no other stall source.
module tree_loader #(
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [31:0]                         in_data,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic                                node_we,
    output logic [$clog2(N_NODE_AND_LEAFS)-1:0] node_waddr,
    output logic [63:0]                         node_wdata,
    output logic                                feat_we,
    output logic [$clog2(N_FEATURE)-1:0]        feat_waddr,
    output logic [31:0]                         feat_wdata,
    output logic                                load_busy,
    output logic                                load_done,
    output logic                                err,
    output logic [1:0]                          err_code
);
    localparam int NA = $clog2(N_NODE_AND_LEAFS);
    localparam int FA = $clog2(N_FEATURE);
    localparam logic [15:0] MAX_N = 16'(N_NODE_AND_LEAFS);
    localparam logic [15:0] MAX_F = 16'(N_FEATURE);

    localparam logic [1:0] ERR_HDR  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_NODE = 2'd3;

    typedef enum logic [2:0] {IDLE, NODE_LO, NODE_HI, FEAT, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  pad_hi;
        logic [7:0]  right;
        logic [7:0]  f_index;
        logic [6:0]  pad_lo;
        logic        is_decision;
    } node_t;

    state_t      state_q, state_d;
    logic [NA:0] node_cnt, n_nodes;
    logic [FA:0] feat_cnt, n_feats;
    logic [31:0] lo_q;

    logic        hs;
    logic [15:0] hdr_n, hdr_f;
    logic        hdr_ok;
    node_t       entry;
    logic        node_ok;
    logic        last_node, last_feat;

    logic        hdr_take, lo_take, node_wr, feat_wr, err_set;
    logic [1:0]  err_val;

    assign hs     = in_valid && in_ready;
    assign hdr_n  = in_data[15:0];
    assign hdr_f  = in_data[31:16];
    assign hdr_ok = (hdr_n != 16'd0) && (hdr_n <= MAX_N) &&
                    (hdr_f != 16'd0) && (hdr_f <= MAX_F);

    // Leaves carry only a value; child/feature indices matter for decision nodes only.
    assign entry   = node_t'({in_data, lo_q});
    assign node_ok = !entry.is_decision ||
                     ((32'(entry.right) > 32'(node_cnt)) &&
                      (32'(entry.right) < 32'(n_nodes)) &&
                      (32'(entry.f_index) < 32'(n_feats)));

    assign last_node = (node_cnt + (NA+1)'(1)) == n_nodes;
    assign last_feat = (feat_cnt + (FA+1)'(1)) == n_feats;

    assign in_ready  = (state_q != DONE);
    assign load_done = (state_q == DONE);
    assign load_busy = (state_q == NODE_LO) || (state_q == NODE_HI) ||
                       (state_q == FEAT) || (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hdr_take = 1'b0;
        lo_take  = 1'b0;
        node_wr  = 1'b0;
        feat_wr  = 1'b0;
        err_set  = 1'b0;
        err_val  = 2'd0;
        if (state_q == DONE) begin
            state_d = IDLE;
        end else if (hs) begin
            case (state_q)
                IDLE: begin
                    hdr_take = 1'b1;
                    if (!hdr_ok) begin
                        err_set = 1'b1;
                        err_val = ERR_HDR;
                        state_d = in_last ? IDLE : DRAIN;
                    end else if (in_last) begin
                        err_set = 1'b1;
                        err_val = ERR_LEN;
                    end else begin
                        state_d = NODE_LO;
                    end
                end
                NODE_LO: begin
                    if (in_last) begin
                        err_set = 1'b1;
                        err_val = ERR_LEN;
                        state_d = IDLE;
                    end else begin
                        lo_take = 1'b1;
                        state_d = NODE_HI;
                    end
                end
                NODE_HI: begin
                    if (in_last) begin
                        err_set = 1'b1;
                        err_val = ERR_LEN;
                        state_d = IDLE;
                    end else if (!node_ok) begin
                        err_set = 1'b1;
                        err_val = ERR_NODE;
                        state_d = DRAIN;
                    end else begin
                        node_wr = 1'b1;
                        state_d = last_node ? FEAT : NODE_LO;
                    end
                end
                FEAT: begin
                    if (last_feat) begin
                        feat_wr = 1'b1;
                        if (in_last) begin
                            state_d = DONE;
                        end else begin
                            err_set = 1'b1;
                            err_val = ERR_LEN;
                            state_d = DRAIN;
                        end
                    end else if (in_last) begin
                        err_set = 1'b1;
                        err_val = ERR_LEN;
                        state_d = IDLE;
                    end else begin
                        feat_wr = 1'b1;
                    end
                end
                DRAIN: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters and the pending low word of the current node entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_cnt <= '0;
            feat_cnt <= '0;
            n_nodes  <= '0;
            n_feats  <= '0;
            lo_q     <= '0;
        end else begin
            if (hdr_take) begin
                node_cnt <= '0;
                feat_cnt <= '0;
                n_nodes  <= hdr_n[NA:0];
                n_feats  <= hdr_f[FA:0];
            end
            if (lo_take) begin
                lo_q <= in_data;
            end
            if (node_wr) begin
                node_cnt <= node_cnt + (NA+1)'(1);
            end
            if (feat_wr) begin
                feat_cnt <= feat_cnt + (FA+1)'(1);
            end
        end
    end

    // A new header restarts error tracking; within a frame the first error is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (hdr_take) begin
            err      <= err_set;
            err_code <= err_val;
        end else if (err_set && !err) begin
            err      <= 1'b1;
            err_code <= err_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_we    <= 1'b0;
            node_waddr <= '0;
            node_wdata <= '0;
            feat_we    <= 1'b0;
            feat_waddr <= '0;
            feat_wdata <= '0;
        end else begin
            node_we <= node_wr;
            feat_we <= feat_wr;
            if (node_wr) begin
                node_waddr <= node_cnt[NA-1:0];
                node_wdata <= entry;
            end
            if (feat_wr) begin
                feat_waddr <= feat_cnt[FA-1:0];
                feat_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_tree_loader.sv
// Bench for tree_loader: directed frames plus random frames checked against a frame-level parse model.
module tb_tree_loader;
    localparam int NN = 256;
    localparam int NF = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        node_we;
    logic [7:0]  node_waddr;
    logic [63:0] node_wdata;
    logic        feat_we;
    logic [4:0]  feat_waddr;
    logic [31:0] feat_wdata;
    logic        load_busy, load_done, err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    tree_loader #(.N_NODE_AND_LEAFS(NN), .N_FEATURE(NF)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .node_we(node_we),
        .node_waddr(node_waddr), .node_wdata(node_wdata), .feat_we(feat_we),
        .feat_waddr(feat_waddr), .feat_wdata(feat_wdata), .load_busy(load_busy),
        .load_done(load_done), .err(err), .err_code(err_code)
    );

    int checks = 0;
    int errors = 0;

    logic [71:0] mon_node[$];
    logic [71:0] exp_node[$];
    logic [36:0] mon_feat[$];
    logic [36:0] exp_feat[$];
    int          done_cnt = 0;
    logic [32:0] frm[$];
    logic        ld_next, probe_busy, probe_err;
    logic [1:0]  probe_code;
    int          exp_code;
    bit          exp_done;

    always @(negedge clk) begin
        if (node_we) mon_node.push_back({node_waddr, node_wdata});
        if (feat_we) mon_feat.push_back({feat_waddr, feat_wdata});
        if (load_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk_node(logic [31:0] val, logic [7:0] r, logic [7:0] f, logic dec);
        return {val, 8'h00, r, f, 7'h00, dec};
    endfunction

    task automatic push_node(input logic [63:0] e);
        frm.push_back({1'b0, e[31:0]});
        frm.push_back({1'b0, e[63:32]});
    endtask

    task automatic mark_last();
        logic [32:0] w;
        w = frm.pop_back();
        w[32] = 1'b1;
        frm.push_back(w);
    endtask

    task automatic clear_mon();
        mon_node.delete();
        mon_feat.delete();
        done_cnt = 0;
    endtask

    task automatic build_good();
        frm.delete();
        frm.push_back({1'b0, 16'd2, 16'd3});
        push_node(mk_node(32'd100, 8'd2, 8'd1, 1'b1));
        push_node(mk_node(32'd7, 8'd0, 8'd0, 1'b0));
        push_node(mk_node(-32'sd5, 8'd0, 8'd0, 1'b0));
        frm.push_back({1'b0, 32'd50});
        frm.push_back({1'b0, 32'd200});
        mark_last();
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int  guard;
        logic r;
        guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!r && guard < 50);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout in_ready=%0b want 1", r);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input int probe);
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_word(frm[i][31:0], frm[i][32]);
            if (i == probe) begin
                @(negedge clk);
                probe_busy = load_busy;
                probe_err  = err;
                probe_code = err_code;
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        ld_next = load_done;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Frame-level reference: walks the word list by node/feature index.
    task automatic model(output int code, output bit done);
        logic [31:0] hdr;
        logic [63:0] e;
        int n, f, last_i, idx;
        exp_node.delete();
        exp_feat.delete();
        code = 0;
        done = 0;
        last_i = frm.size() - 1;
        hdr = frm[0][31:0];
        n = int'(hdr[15:0]);
        f = int'(hdr[31:16]);
        if (n < 1 || n > NN || f < 1 || f > NF) begin code = 1; return; end
        if (last_i == 0) begin code = 2; return; end
        for (int i = 0; i < n; i++) begin
            if (last_i <= 2 + 2*i) begin code = 2; return; end
            e = {frm[2 + 2*i][31:0], frm[1 + 2*i][31:0]};
            if (e[0] && !(int'(e[23:16]) > i && int'(e[23:16]) < n && int'(e[15:8]) < f)) begin
                code = 3;
                return;
            end
            exp_node.push_back({8'(i), e});
        end
        for (int j = 0; j < f; j++) begin
            idx = 1 + 2*n + j;
            if (j < f - 1 && last_i == idx) begin code = 2; return; end
            exp_feat.push_back({5'(j), frm[idx][31:0]});
            if (j == f - 1) begin
                if (last_i == idx) done = 1;
                else code = 2;
                return;
            end
        end
    endtask

    task automatic gen_random();
        int n, f, mode, bad_i, s;
        logic [63:0] e;
        frm.delete();
        n = $urandom_range(1, 6);
        f = $urandom_range(1, 5);
        mode = $urandom_range(0, 4);
        if (mode == 1) begin
            case ($urandom_range(0, 3))
                0: n = 0;
                1: f = 0;
                2: f = 33;
                default: n = 257;
            endcase
            frm.push_back({1'b0, 16'(f), 16'(n)});
            repeat ($urandom_range(0, 3)) frm.push_back({1'b0, $urandom()});
            mark_last();
            return;
        end
        frm.push_back({1'b0, 16'(f), 16'(n)});
        bad_i = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++) begin
            if (i < n - 1 && $urandom_range(0, 1) == 1) begin
                e = {$urandom(), 8'($urandom()), 8'($urandom_range(i + 1, n - 1)),
                     8'($urandom_range(0, f - 1)), 7'($urandom()), 1'b1};
            end else begin
                e = {$urandom(), $urandom()};
                e[0] = 1'b0;
            end
            if (mode == 2 && i == bad_i) begin
                e = {$urandom(), 8'($urandom()), 8'($urandom_range(0, i)),
                     8'($urandom_range(0, f - 1)), 7'($urandom()), 1'b1};
            end
            push_node(e);
        end
        for (int j = 0; j < f; j++) frm.push_back({1'b0, $urandom()});
        if (mode == 4) repeat ($urandom_range(1, 3)) frm.push_back({1'b0, $urandom()});
        if (mode == 3) begin
            s = $urandom_range(1, frm.size() - 1);
            while (frm.size() > s) void'(frm.pop_back());
        end
        mark_last();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, node_we, feat_we, load_busy, load_done, err, err_code} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 10000000",
                     {in_ready, node_we, feat_we, load_busy, load_done, err, err_code});
        end
        checks++;
        if ({node_waddr, node_wdata, feat_waddr, feat_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_wr_regs got %h want 0", {node_waddr, node_wdata, feat_waddr, feat_wdata});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [71:0] want_n[3];
        logic [36:0] want_f[2];
        want_n[0] = {8'd0, 64'h00000064_00020101};
        want_n[1] = {8'd1, 64'h00000007_00000000};
        want_n[2] = {8'd2, 64'hFFFFFFFB_00000000};
        want_f[0] = {5'd0, 32'd50};
        want_f[1] = {5'd1, 32'd200};
        build_good();
        clear_mon();
        send_frame(1'b0, 0);
        checks++;
        if (probe_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", probe_busy); end
        checks++;
        if (mon_node.size() != 3) begin
            errors++; $display("FAIL basic_node_cnt got %0d want 3", mon_node.size());
        end else for (int i = 0; i < 3; i++) begin
            checks++;
            if (mon_node[i] !== want_n[i]) begin errors++; $display("FAIL basic_node%0d got %h want %h", i, mon_node[i], want_n[i]); end
        end
        checks++;
        if (mon_feat.size() != 2) begin
            errors++; $display("FAIL basic_feat_cnt got %0d want 2", mon_feat.size());
        end else for (int i = 0; i < 2; i++) begin
            checks++;
            if (mon_feat[i] !== want_f[i]) begin errors++; $display("FAIL basic_feat%0d got %h want %h", i, mon_feat[i], want_f[i]); end
        end
        checks++;
        if (ld_next !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL basic_done got next=%b cnt=%0d want 1/1", ld_next, done_cnt);
        end
        checks++;
        if ({err, err_code, load_busy} !== 4'b0000) begin
            errors++; $display("FAIL basic_end_state got %b want 0000", {err, err_code, load_busy});
        end
    endtask

    task automatic test_bad_header();
        frm.delete();
        frm.push_back({1'b0, 16'd4, 16'd0});
        frm.push_back({1'b0, 32'h1111});
        frm.push_back({1'b0, 32'h2222});
        frm.push_back({1'b1, 32'h3333});
        clear_mon();
        send_frame(1'b0, 0);
        checks++;
        if ({probe_err, probe_code, probe_busy} !== 4'b1010) begin
            errors++; $display("FAIL badhdr_drain got %b want 1010", {probe_err, probe_code, probe_busy});
        end
        checks++;
        if (mon_node.size() + mon_feat.size() != 0 || done_cnt != 0 || ld_next !== 1'b0) begin
            errors++; $display("FAIL badhdr_writes got %0d/%0d done=%0d want 0/0/0",
                               mon_node.size(), mon_feat.size(), done_cnt);
        end
        checks++;
        if ({err, err_code, in_ready, load_busy} !== 5'b10110) begin
            errors++; $display("FAIL badhdr_end got %b want 10110", {err, err_code, in_ready, load_busy});
        end
    endtask

    task automatic test_bad_node();
        frm.delete();
        frm.push_back({1'b0, 16'd2, 16'd3});
        push_node(mk_node(32'd9, 8'd5, 8'd0, 1'b1));
        push_node(mk_node(32'd1, 8'd0, 8'd0, 1'b0));
        push_node(mk_node(32'd2, 8'd0, 8'd0, 1'b0));
        frm.push_back({1'b0, 32'd3});
        frm.push_back({1'b0, 32'd4});
        mark_last();
        clear_mon();
        send_frame(1'b0, -1);
        checks++;
        if ({err, err_code} !== 3'b111) begin errors++; $display("FAIL badnode_code got %b want 111", {err, err_code}); end
        checks++;
        if (mon_node.size() + mon_feat.size() != 0 || done_cnt != 0) begin
            errors++; $display("FAIL badnode_writes got %0d/%0d done=%0d want 0/0/0",
                               mon_node.size(), mon_feat.size(), done_cnt);
        end
        build_good();
        clear_mon();
        send_frame(1'b0, 0);
        checks++;
        if (probe_err !== 1'b0) begin errors++; $display("FAIL badnode_clear got %b want 0", probe_err); end
        checks++;
        if (done_cnt != 1 || mon_node.size() != 3 || mon_feat.size() != 2 || err !== 1'b0) begin
            errors++; $display("FAIL badnode_recover got done=%0d n=%0d f=%0d err=%b want 1/3/2/0",
                               done_cnt, mon_node.size(), mon_feat.size(), err);
        end
    endtask

    task automatic test_early_last();
        frm.delete();
        frm.push_back({1'b0, 16'd3, 16'd1});
        push_node(mk_node(32'd42, 8'd0, 8'd0, 1'b0));
        frm.push_back({1'b0, 32'd11});
        frm.push_back({1'b1, 32'd22});
        clear_mon();
        send_frame(1'b0, -1);
        checks++;
        if ({err, err_code} !== 3'b110) begin errors++; $display("FAIL early_code got %b want 110", {err, err_code}); end
        checks++;
        if (mon_feat.size() != 1) begin
            errors++; $display("FAIL early_feat_cnt got %0d want 1", mon_feat.size());
        end else begin
            checks++;
            if (mon_feat[0] !== {5'd0, 32'd11}) begin errors++; $display("FAIL early_feat0 got %h want %h", mon_feat[0], {5'd0, 32'd11}); end
        end
        checks++;
        if ({in_ready, load_busy} !== 2'b10 || done_cnt != 0) begin
            errors++; $display("FAIL early_idle got %b done=%0d want 10/0", {in_ready, load_busy}, done_cnt);
        end
    endtask

    task automatic test_gaps();
        build_good();
        model(exp_code, exp_done);
        clear_mon();
        send_frame(1'b1, -1);
        checks++;
        if (mon_node !== exp_node || mon_feat !== exp_feat) begin
            errors++; $display("FAIL gaps_writes got %0d/%0d entries want %0d/%0d",
                               mon_node.size(), mon_feat.size(), exp_node.size(), exp_feat.size());
        end
        checks++;
        if (ld_next !== exp_done || done_cnt != 1 || err !== 1'b0) begin
            errors++; $display("FAIL gaps_done got next=%b cnt=%0d err=%b want 1/1/0", ld_next, done_cnt, err);
        end
    endtask

    task automatic test_reset_mid();
        build_good();
        for (int i = 0; i < 4; i++) send_word(frm[i][31:0], frm[i][32]);
        clear_mon();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, node_we, feat_we, load_busy, load_done, err, err_code} !== 8'b1000_0000) begin
            errors++; $display("FAIL rstmid_outputs got %b want 10000000",
                               {in_ready, node_we, feat_we, load_busy, load_done, err, err_code});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (mon_node.size() + mon_feat.size() != 0 || done_cnt != 0) begin
            errors++; $display("FAIL rstmid_writes got %0d want 0", mon_node.size() + mon_feat.size());
        end
        model(exp_code, exp_done);
        clear_mon();
        send_frame(1'b0, -1);
        checks++;
        if (mon_node !== exp_node || mon_feat !== exp_feat || done_cnt != 1) begin
            errors++; $display("FAIL rstmid_reload got %0d/%0d done=%0d want %0d/%0d/1",
                               mon_node.size(), mon_feat.size(), done_cnt, exp_node.size(), exp_feat.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            gen_random();
            model(exp_code, exp_done);
            clear_mon();
            send_frame(1'($urandom_range(0, 1)), -1);
            checks++;
            if (mon_node.size() != exp_node.size()) begin
                errors++; $display("FAIL rnd%0d_node_cnt got %0d want %0d", t, mon_node.size(), exp_node.size());
            end else foreach (exp_node[i]) begin
                checks++;
                if (mon_node[i] !== exp_node[i]) begin errors++; $display("FAIL rnd%0d_node%0d got %h want %h", t, i, mon_node[i], exp_node[i]); end
            end
            checks++;
            if (mon_feat.size() != exp_feat.size()) begin
                errors++; $display("FAIL rnd%0d_feat_cnt got %0d want %0d", t, mon_feat.size(), exp_feat.size());
            end else foreach (exp_feat[i]) begin
                checks++;
                if (mon_feat[i] !== exp_feat[i]) begin errors++; $display("FAIL rnd%0d_feat%0d got %h want %h", t, i, mon_feat[i], exp_feat[i]); end
            end
            checks++;
            if (err !== (exp_code != 0) || int'(err_code) != exp_code) begin
                errors++; $display("FAIL rnd%0d_err got %b/%0d want %0b/%0d", t, err, err_code, exp_code != 0, exp_code);
            end
            checks++;
            if (done_cnt != int'(exp_done) || ld_next !== exp_done) begin
                errors++; $display("FAIL rnd%0d_done got %0d/%b want %0d", t, done_cnt, ld_next, exp_done);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_bad_header();
        test_bad_node();
        test_early_last();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
